// File: rtl/mul_arbiter.sv
// -----------------------------------------------------------------------------
// mul_arbiter
//
// Shares one repeated-addition multiplier among N requesters. A round-robin
// arbiter picks a requester while the block is idle, the operands of that
// requester are captured, and the product is built by adding A into P once
// per count of B. The result is reported with a one-cycle done pulse.
//
// Handshake (req/gnt): req[i] is a level request with a_in/b_in slice i valid
// while it is high. The operands are captured on the clock edge that leaves
// IDLE. gnt[i] pulses for exactly one cycle after that edge. A requester drops
// req[i] in its gnt cycle unless it wants another job. A req still high at the
// next IDLE is treated as a new request. Operand changes after the capture
// edge have no effect on the running job.
//
// Ports:
//   clk         clock, rising edge
//   rst         asynchronous, active-high reset
//   req[N]      request per requester (level)
//   a_in[N*W]   multiplicand, requester i at [i*W +: W]
//   b_in[N*W]   multiplier / repeat count, same packing
//   gnt[N]      one-hot, one-cycle pulse: operands of that requester captured
//   busy        high whenever the FSM is not IDLE
//   done        one-cycle pulse: product valid
//   done_id     index of the requester whose job finished
//   product     result, held until the next done
//   o_dbg_state current FSM state (0=IDLE, 1=RUN, 2=DONE)
// -----------------------------------------------------------------------------
module mul_arbiter #(
   parameter int W = 16,
   parameter int N = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N-1:0]         req,
   input  logic [N*W-1:0]       a_in,
   input  logic [N*W-1:0]       b_in,
   output logic [N-1:0]         gnt,
   output logic                 busy,
   output logic                 done,
   output logic [$clog2(N)-1:0] done_id,
   output logic [W-1:0]         product,
   output logic [1:0]           o_dbg_state
);

   localparam int IW = $clog2(N);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   // ---------------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------------
   state_t          r_state;
   logic [IW-1:0]   r_owner;
   logic [IW-1:0]   r_last;
   logic [N-1:0]    r_gnt;
   logic            r_busy;
   logic            r_done;
   logic [IW-1:0]   r_done_id;
   logic [W-1:0]    r_product;

   // Datapath registers
   logic [W-1:0]    r_a;
   logic [W-1:0]    r_b;
   logic [W-1:0]    r_p;

   // ---------------------------------------------------------------------------
   // Wires
   // ---------------------------------------------------------------------------
   logic            w_any;
   logic [IW-1:0]   w_win;
   logic [N-1:0]    w_win_onehot;
   logic [W-1:0]    w_a_arr [N];
   logic [W-1:0]    w_b_arr [N];
   logic [W-1:0]    w_a_sel;
   logic [W-1:0]    w_b_sel;
   logic            w_eqz;
   logic            w_load;
   logic            w_clear;
   logic            w_dec;

   // ---------------------------------------------------------------------------
   // Operand unpacking
   // ---------------------------------------------------------------------------
   always_comb begin
      for (int i = 0; i < N; i++) begin
         w_a_arr[i] = a_in[i*W +: W];
         w_b_arr[i] = b_in[i*W +: W];
      end
   end

   // ---------------------------------------------------------------------------
   // Round-robin winner search: first requester with req high, starting one
   // past the last winner and wrapping modulo N. With r_last reset to N-1 the
   // search starts at requester 0.
   // ---------------------------------------------------------------------------
   always_comb begin
      logic [IW-1:0] w_idx;
      w_any = 1'b0;
      w_win = '0;
      w_idx = '0;
      for (int k = 1; k <= N; k++) begin
         w_idx = IW'((int'(r_last) + k) % N);
         if (!w_any && req[w_idx]) begin
            w_any = 1'b1;
            w_win = w_idx;
         end
      end
   end

   assign w_win_onehot = {{(N-1){1'b0}}, 1'b1} << w_win;
   assign w_a_sel      = w_a_arr[w_win];
   assign w_b_sel      = w_b_arr[w_win];

   // ---------------------------------------------------------------------------
   // Datapath controls decoded from the current state
   // ---------------------------------------------------------------------------
   assign w_eqz   = (r_b == '0);
   assign w_load  = (r_state == S_IDLE) && w_any;
   assign w_clear = w_load;
   // The zero-check cycle in RUN performs no add, so B=0 gives P=0.
   assign w_dec   = (r_state == S_RUN) && !w_eqz;

   // ---------------------------------------------------------------------------
   // Datapath: operand A, down-counter B, product accumulator P
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_a <= '0;
         r_b <= '0;
         r_p <= '0;
      end else begin
         if (w_load) begin
            r_a <= w_a_sel;
            r_b <= w_b_sel;
         end else if (w_dec) begin
            r_b <= r_b - 1'b1;
         end

         // Addition wraps modulo 2^W; overflow is dropped silently.
         if (w_clear) begin
            r_p <= '0;
         end else if (w_dec) begin
            r_p <= r_p + r_a;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Control FSM with registered outputs
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_owner   <= '0;
         r_last    <= IW'(N-1);
         r_gnt     <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_done_id <= '0;
         r_product <= '0;
      end else begin
         // Pulses default low; they are raised for one cycle below.
         r_gnt  <= '0;
         r_done <= 1'b0;

         case (r_state)
            S_IDLE: begin
               if (w_any) begin
                  r_state <= S_RUN;
                  r_owner <= w_win;
                  r_last  <= w_win;
                  r_gnt   <= w_win_onehot;
                  r_busy  <= 1'b1;
               end
            end

            S_RUN: begin
               if (w_eqz) begin
                  r_state   <= S_DONE;
                  r_done    <= 1'b1;
                  r_done_id <= r_owner;
                  r_product <= r_p;
               end
            end

            S_DONE: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end

            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign gnt         = r_gnt;
   assign busy        = r_busy;
   assign done        = r_done;
   assign done_id     = r_done_id;
   assign product     = r_product;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mul_arbiter.sv
module tb_mul_arbiter;

   localparam int W = 16;
   localparam int N = 4;

   // ---------------------------------------------------------------------------
   // Clock / reset
   // ---------------------------------------------------------------------------
   logic           clk = 1'b0;
   logic           rst;
   logic [N-1:0]   req;
   logic [N*W-1:0] a_in;
   logic [N*W-1:0] b_in;
   logic [N-1:0]   gnt;
   logic           busy;
   logic           done;
   logic [1:0]     done_id;
   logic [W-1:0]   product;
   logic [1:0]     o_dbg_state;

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   mul_arbiter #(.W(W), .N(N)) dut (
      .clk         (clk),
      .rst         (rst),
      .req         (req),
      .a_in        (a_in),
      .b_in        (b_in),
      .gnt         (gnt),
      .busy        (busy),
      .done        (done),
      .done_id     (done_id),
      .product     (product),
      .o_dbg_state (o_dbg_state)
   );

   // ---------------------------------------------------------------------------
   // Scoreboard
   // ---------------------------------------------------------------------------
   int n_checks = 0;
   int n_errors = 0;
   int n_done   = 0;

   logic [W-1:0] exp_q[$];
   logic [1:0]   exp_id_q[$];
   logic [N-1:0] exp_gnt_q[$];

   always @(negedge clk) begin
      if (!rst) begin
         if (gnt !== '0) begin
            logic [N-1:0] e;
            n_checks++;
            if (exp_gnt_q.size() == 0) begin
               n_errors++;
               $display("FAIL gnt_unexpected: got %b, expected no grant", gnt);
            end else begin
               e = exp_gnt_q.pop_front();
               if (gnt !== e) begin
                  n_errors++;
                  $display("FAIL gnt_order: got %b, expected %b", gnt, e);
               end
            end
         end
         if (done === 1'b1) begin
            logic [W-1:0] ep;
            logic [1:0]   ei;
            n_done++;
            n_checks++;
            if (exp_q.size() == 0) begin
               n_errors++;
               $display("FAIL done_unexpected: got done id=%0d product=%h, expected no done",
                        done_id, product);
            end else begin
               ep = exp_q.pop_front();
               ei = exp_id_q.pop_front();
               if (product !== ep || done_id !== ei) begin
                  n_errors++;
                  $display("FAIL done_result: got id=%0d product=%h, expected id=%0d product=%h",
                           done_id, product, ei, ep);
               end
            end
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Driver tasks
   // ---------------------------------------------------------------------------
   task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
      a_in[i*W +: W] = a;
      b_in[i*W +: W] = b;
   endtask

   task automatic push_job(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
      logic [N-1:0] oh;
      oh = '0;
      oh[i] = 1'b1;
      exp_gnt_q.push_back(oh);
      exp_q.push_back(W'(a * b));
      exp_id_q.push_back(2'(i));
   endtask

   // Returns at the falling edge of the cycle in which a masked gnt bit is high.
   task automatic wait_gnt(input logic [N-1:0] mask, input int budget,
                           output int at, output bit ok);
      ok = 1'b0;
      at = 0;
      for (int k = 0; k < budget; k++) begin
         @(negedge clk);
         if ((gnt & mask) != '0) begin
            ok = 1'b1;
            at = cyc;
            break;
         end
      end
   endtask

   task automatic wait_done(input int budget, output int at, output bit ok);
      ok = 1'b0;
      at = 0;
      for (int k = 0; k < budget; k++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            ok = 1'b1;
            at = cyc;
            break;
         end
      end
   endtask

   // ---------------------------------------------------------------------------
   // Tests
   // ---------------------------------------------------------------------------
   task automatic test_reset();
      rst  = 1'b1;
      req  = '0;
      a_in = '0;
      b_in = '0;
      repeat (2) @(negedge clk);
      n_checks++;
      if (gnt !== '0 || busy !== 1'b0 || done !== 1'b0 || done_id !== 2'd0 ||
          product !== '0 || o_dbg_state !== 2'd0) begin
         n_errors++;
         $display("FAIL reset_values: got gnt=%b busy=%b done=%b id=%0d product=%h state=%0d, expected all 0",
                  gnt, busy, done, done_id, product, o_dbg_state);
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_single();
      int g, done_at, busy_cnt;
      bit ok;
      set_op(0, 16'd3, 16'd5);
      push_job(0, 16'd3, 16'd5);
      req = 4'b0001;
      wait_gnt(4'b0001, 10, g, ok);
      req = '0;
      n_checks++;
      if (!ok || busy !== 1'b1) begin
         n_errors++;
         $display("FAIL single_gnt: got ok=%0b busy=%b, expected grant with busy=1", ok, busy);
      end
      busy_cnt = 1;
      done_at  = -100;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (busy === 1'b1) busy_cnt++;
         if (done === 1'b1) done_at = cyc;
      end
      n_checks++;
      if (done_at - g != 6) begin
         n_errors++;
         $display("FAIL single_done_time: got %0d cycles after gnt, expected 6", done_at - g);
      end
      n_checks++;
      if (busy_cnt != 7) begin
         n_errors++;
         $display("FAIL single_busy_len: got %0d, expected 7", busy_cnt);
      end
   endtask

   task automatic test_zero_count();
      int g, d, busy_cnt;
      bit ok, okd;
      logic [W-1:0] p_seen;
      set_op(2, 16'd7, 16'd0);
      push_job(2, 16'd7, 16'd0);
      req = 4'b0100;
      wait_gnt(4'b0100, 10, g, ok);
      req = '0;
      p_seen = dut.r_p;
      busy_cnt = 1;
      wait_done(5, d, okd);
      n_checks++;
      if (!ok || !okd || d - g != 1) begin
         n_errors++;
         $display("FAIL zero_done_time: got ok=%0b/%0b delta=%0d, expected 1", ok, okd, d - g);
      end
      n_checks++;
      if (p_seen !== '0 || dut.r_p !== '0) begin
         n_errors++;
         $display("FAIL zero_no_add: got P=%h/%h, expected 0", p_seen, dut.r_p);
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic test_contention();
      int start, c;
      bit raised;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      set_op(0, 16'd2, 16'd1);
      set_op(1, 16'd3, 16'd2);
      set_op(2, 16'd4, 16'd3);
      set_op(3, 16'd5, 16'd4);
      for (int i = 0; i < N; i++) push_job(i, 16'(i + 2), 16'(i + 1));
      start  = n_done;
      raised = 1'b0;
      req    = 4'b1111;
      for (c = 0; c < 150; c++) begin
         @(negedge clk);
         if (gnt != '0) req = req & ~gnt;
         if (gnt == 4'b1000 && !raised) begin
            raised = 1'b1;
            set_op(0, 16'd6, 16'd2);
            set_op(2, 16'd7, 16'd3);
            push_job(0, 16'd6, 16'd2);
            push_job(2, 16'd7, 16'd3);
            req = req | 4'b0101;
         end
         if (n_done - start >= 6) break;
      end
      req = '0;
      n_checks++;
      if (n_done - start != 6) begin
         n_errors++;
         $display("FAIL contention_jobs: got %0d dones, expected 6", n_done - start);
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic test_overflow();
      int g, d;
      bit ok, okd;
      set_op(1, 16'hFFFF, 16'd2);
      push_job(1, 16'hFFFF, 16'd2);
      req = 4'b0010;
      wait_gnt(4'b0010, 10, g, ok);
      req = '0;
      wait_done(10, d, okd);
      n_checks++;
      if (!ok || !okd || d - g != 3) begin
         n_errors++;
         $display("FAIL overflow_time: got ok=%0b/%0b delta=%0d, expected 3", ok, okd, d - g);
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic test_reset_mid_job();
      int g, start, c;
      bit ok;
      set_op(0, 16'd100, 16'd50);
      exp_gnt_q.push_back(4'b0001);
      req = 4'b0001;
      wait_gnt(4'b0001, 10, g, ok);
      req = '0;
      repeat (9) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      n_checks++;
      if (gnt !== '0 || busy !== 1'b0 || done !== 1'b0 || product !== '0 ||
          o_dbg_state !== 2'd0) begin
         n_errors++;
         $display("FAIL reset_async: got gnt=%b busy=%b done=%b product=%h state=%0d, expected all 0",
                  gnt, busy, done, product, o_dbg_state);
      end
      set_op(0, 16'd5, 16'd3);
      set_op(1, 16'd4, 16'd2);
      req = 4'b0011;
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b0 || o_dbg_state !== 2'd0) begin
         n_errors++;
         $display("FAIL reset_wins: got busy=%b state=%0d, expected idle", busy, o_dbg_state);
      end
      push_job(0, 16'd5, 16'd3);
      push_job(1, 16'd4, 16'd2);
      start = n_done;
      rst = 1'b0;
      for (c = 0; c < 60; c++) begin
         @(negedge clk);
         if (gnt != '0) req = req & ~gnt;
         if (n_done - start >= 2) break;
      end
      req = '0;
      n_checks++;
      if (n_done - start != 2) begin
         n_errors++;
         $display("FAIL reset_followup: got %0d dones, expected 2", n_done - start);
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic test_operand_hold();
      int g, d;
      bit ok, okd;
      set_op(3, 16'd9, 16'd4);
      push_job(3, 16'd9, 16'd4);
      req = 4'b1000;
      wait_gnt(4'b1000, 10, g, ok);
      req = '0;
      set_op(3, 16'($urandom_range(10, 200)), 16'($urandom_range(5, 9)));
      @(negedge clk);
      set_op(3, 16'($urandom_range(10, 200)), 16'($urandom_range(5, 9)));
      wait_done(20, d, okd);
      n_checks++;
      if (!ok || !okd || d - g != 5) begin
         n_errors++;
         $display("FAIL hold_time: got ok=%0b/%0b delta=%0d, expected 5", ok, okd, d - g);
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic test_back_to_back();
      int g1, g2, d;
      bit ok1, ok2, okd;
      set_op(1, 16'd3, 16'd2);
      push_job(1, 16'd3, 16'd2);
      push_job(1, 16'd3, 16'd2);
      req = 4'b0010;
      wait_gnt(4'b0010, 10, g1, ok1);
      wait_gnt(4'b0010, 20, g2, ok2);
      req = '0;
      n_checks++;
      if (!ok1 || !ok2 || g2 - g1 != 5) begin
         n_errors++;
         $display("FAIL b2b_spacing: got ok=%0b/%0b spacing=%0d, expected 5", ok1, ok2, g2 - g1);
      end
      wait_done(20, d, okd);
      repeat (3) @(negedge clk);
   endtask

   task automatic test_random();
      int i, g, d, start;
      bit ok, okd;
      logic [W-1:0] a, b;
      start = n_done;
      for (int j = 0; j < 8; j++) begin
         i = $urandom_range(0, N - 1);
         a = 16'($urandom_range(0, 65535));
         b = 16'($urandom_range(0, 8));
         set_op(i, a, b);
         push_job(i, a, b);
         req = '0;
         req[i] = 1'b1;
         wait_gnt(req, 10, g, ok);
         req = '0;
         wait_done(20, d, okd);
         n_checks++;
         if (!ok || !okd || d - g != int'(b) + 1) begin
            n_errors++;
            $display("FAIL random_time: job %0d got ok=%0b/%0b delta=%0d, expected %0d",
                     j, ok, okd, d - g, int'(b) + 1);
         end
         @(negedge clk);
      end
      n_checks++;
      if (n_done - start != 8) begin
         n_errors++;
         $display("FAIL random_jobs: got %0d dones, expected 8", n_done - start);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Sequence and report
   // ---------------------------------------------------------------------------
   initial begin
      test_reset();
      test_single();
      test_zero_count();
      test_contention();
      test_overflow();
      test_reset_mid_job();
      test_operand_hold();
      test_back_to_back();
      test_random();
      repeat (5) @(negedge clk);
      n_checks++;
      if (exp_q.size() != 0 || exp_gnt_q.size() != 0) begin
         n_errors++;
         $display("FAIL scoreboard_drain: got %0d results and %0d grants pending, expected 0",
                  exp_q.size(), exp_gnt_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/mul_arbiter.md
# mul_arbiter

Shares one repeated-addition multiplier (operand register A, product register P with clear, down-counter B, adder, zero-detect) among N requesters. Each job is sequenced as load, clear, accumulate until the counter reaches zero, then report the result. Arbitration is round-robin. The block contains its own datapath instance and the FSM that drives its load, clear and decrement controls. It sits between client blocks and the shared arithmetic resource.

## Interface
Parameters:
- W, 16, operand/product width
- N, 4, number of requesters (≥2)

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- req  in  N  request per requester; level, held until that requester's gnt
- a_in  in  N*W  multiplicand, requester i at bits [i*W +: W]
- b_in  in  N*W  multiplier (repeat count), same packing
- gnt  out  N  one-hot, one-cycle pulse: operands of that requester were captured
- busy  out  1  high whenever FSM is not IDLE
- done  out  1  one-cycle pulse: product valid
- done_id  out  $clog2(N)  index of requester whose job finished
- product  out  W  result; holds last value until next done

## Operation
- Reset values:
  - Outputs: gnt=0, busy=0, done=0, done_id=0, product=0.
  - Internal: A=0, B=0, P=0, owner=0, round-robin pointer last=N-1, so requester 0 wins first.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - If any req is high, the winner is the first requester with req high, searching last+1, last+2, … mod N.
  - At the clock edge the block loads A←a_in[win], B←b_in[win], clears P←0, sets owner←win and last←win, and goes to RUN.
  - With no req it stays in IDLE.
- RUN:
  - If B==0 (eqz), go to DONE; no add occurs that cycle.
  - Otherwise P←P+A (mod 2^W) and B←B−1.
  - A is constant during the job.
- DONE:
  - done=1, done_id=owner.
  - product is registered from P on entry to DONE and held afterwards.
  - Next state is IDLE unconditionally.
- gnt is registered and is high only for the first RUN cycle, bit owner.
- Requester rules:
  - A requester must drop req in its gnt cycle unless it wants another job.
  - A req still high at the next IDLE is a new request.
  - Operands are sampled only at the capture edge; later changes to a_in/b_in are ignored.
- Arithmetic: product = (a × b) mod 2^W. Overflow is silently truncated; there is no saturation or flag.
- B=0 yields product 0 with no accumulate cycles.
- A=0 yields product 0 after b accumulate cycles.
- A request arriving while busy waits; no preemption.
- Requesters whose req drops before being granted are simply skipped.

## Timing
- Capture edge = E0, the IDLE→RUN edge.
- RUN lasts b+1 cycles: b adds plus one zero-check cycle.
- done is high in the cycle following edge E0+b+1, i.e. the (b+2)th cycle after E0.
- Per-job occupancy is b+3 cycles including the mandatory IDLE cycle. Back-to-back grant spacing = b+3 cycles.
- Maximum RUN length is 2^W cycles, for b=2^W−1; there is no timeout.
- busy rises in the cycle after E0 and falls in the cycle after DONE.
- Reset mid-operation:
  - All state and outputs return to reset values immediately, asynchronously.
  - The in-flight job is discarded with no done.
  - The pointer returns to N-1.
- Simultaneous rst and req: rst wins; no capture.

## Test plan
- Single job: req[0]=1, a=3, b=5, others idle.
  - gnt=0001 in the cycle after E0.
  - done in cycle E0+7 with product=15, done_id=0.
  - busy high for exactly 7 cycles.
- Zero count: requester 2 with a=7, b=0.
  - done two cycles after gnt's cycle edge (E0+2), product=0, done_id=2.
  - No add observed on P.
- Full contention after reset:
  - All four req high with distinct operands (e.g. 2×1, 3×2, 4×3, 5×4).
  - Grant order 0,1,2,3 with products 2, 6, 12, 20.
  - Each requester drops req on its gnt.
  - Then raise req[0] and req[2] while requester 3 runs: next order is 0 then 2.
- Overflow: a=16'hFFFF, b=2 -> product=16'hFFFE, done at E0+4.
- Reset mid-job:
  - Start a=100, b=50.
  - Pulse rst 10 cycles after E0: busy/gnt/done/product drop to 0 immediately and no done follows.
  - With req[1] and req[0] high after reset, requester 0 is granted first.
- Operand hold: change a_in/b_in of the owner during RUN -> product still reflects captured values (e.g. 9×4=36).
